onehot_enc_pipe: RTL and testbench
==================================

Name: onehot_enc_pipe

Overview:
- Pipelined, flow-controlled one-hot to binary encoder with validity checking.
- Sits between arbiter/grant logic and downstream index consumers (mux selects, FIFO write pointers).
- Replaces bare combinational encoding where timing needs registering and back-pressure.
- Flags zero-hot and multi-hot words and keeps a saturating error count.

Parameters:
- ONEHOT_WIDTH, 16, input vector width; legal range 2..256.
- BIN_WIDTH, $clog2(ONEHOT_WIDTH), output index width.
- LATENCY, 2, register stages from input to output; legal values 1..4.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous active-high reset.
- in_onehot  in  ONEHOT_WIDTH  word to encode.
- in_valid  in  1  in_onehot is valid.
- in_ready  out  1  block accepts the word this cycle.
- out_bin  out  BIN_WIDTH  encoded index.
- out_zero  out  1  accepted word had no bits set.
- out_multi  out  1  accepted word had more than one bit set.
- out_valid  out  1  out_* fields are valid.
- out_ready  in  1  downstream accepts this cycle.
- err_clr  in  1  synchronous clear of err_count.
- err_count  out  ERR_CNT_WIDTH  saturating count of bad words.

Behaviour:
- Interface: one clock, clk. Reset arst is asynchronous and active-high.
- Reset: all stage valid bits, out_valid, out_bin, out_zero, out_multi and err_count go to 0. in_ready is 1 as soon as arst deasserts.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Pipeline: LATENCY-deep elastic register chain, each stage holding valid plus payload.
  - Stage k loads when it is empty or stage k+1 loads in the same cycle (last stage: when out_ready).
  - in_ready = stage-0 load condition. This is a combinational path from out_ready, which is acceptable.
- Throughput and latency: one word per cycle when out_ready is held high. A word accepted at cycle t appears with out_valid at t+LATENCY.
- Stall: with out_ready low, the data is held unchanged and out_valid stays high. A full pipe deasserts in_ready. No word is dropped or duplicated.
- Encoding, computed in stage 0 and carried forward:
  - out_zero = (in_onehot == 0).
  - out_multi = more than one bit set.
  - out_bin per the Optional Feature rule.
  - A zero word gives out_bin = 0.
- err_count:
  - Increments by 1 on each input transfer with zero or multi set, including zero-hot words.
  - Saturates at all-ones with no wrap.
  - err_clr takes priority over a same-cycle increment and results in 0.
- Reset mid-operation: all in-flight words are discarded and no partial output is produced.
- in_onehot is ignored when in_valid is low.
- ONEHOT_WIDTH not a power of two: indices ≥ ONEHOT_WIDTH never occur. BIN_WIDTH is still $clog2.

Optional Feature:
- Macro: ONEHOT_ENC_PRIORITY_EN.
- Defined: out_bin is the index of the lowest set bit, so multi-hot words encode deterministically.
- Undefined: out_bin bit j is the OR of bit j of every set index (legacy OR-encoding). Multi-hot results are the OR of the indices.
- out_multi, out_zero and err_count behave identically in both builds.

Test Plan:
- ONEHOT_WIDTH=16, LATENCY=2, out_ready=1: stream 0x0001, 0x0080, 0x8000 on consecutive cycles -> out_bin 0, 7, 15 on cycles t+2, t+3, t+4; out_zero=out_multi=0; err_count=0.
- Multi-hot 0x0014 (bits 2,4) -> out_multi=1, err_count=1. out_bin=2 with PRIORITY_EN, out_bin=6 without.
- Zero word 0x0000 -> out_bin=0, out_zero=1, err_count increments. Same-cycle err_clr -> err_count=0.
- Back-pressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly LATENCY words accepted, then in_ready=0, outputs stable. On release, words emerge in order with none lost.
- ERR_CNT_WIDTH=2: feed 5 bad words -> err_count reads 1, 2, 3, 3, 3.
- Assert arst with 2 words in flight -> out_valid=0 and err_count=0 immediately (asynchronous). After release, the first new word emerges LATENCY cycles after acceptance.

Source files
------------

// File: rtl/onehot_enc_pipe.sv
// Pipelined, flow-controlled one-hot to binary encoder with zero/multi-hot flags
// and a saturating error counter. Define ONEHOT_ENC_PRIORITY_EN for lowest-set-bit encoding.
module onehot_enc_pipe #(
  parameter int ONEHOT_WIDTH  = 16,
  parameter int BIN_WIDTH     = $clog2(ONEHOT_WIDTH),
  parameter int LATENCY       = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [ONEHOT_WIDTH-1:0]  in_onehot,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [BIN_WIDTH-1:0]     out_bin,
  output logic                     out_zero,
  output logic                     out_multi,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef struct packed {
    logic [BIN_WIDTH-1:0] bin;
    logic                 zero;
    logic                 multi;
  } payload_t;

  payload_t                      enc;
  logic     [LATENCY-1:0]        valid_q, valid_d, load, up_valid;
  payload_t [LATENCY-1:0]        data_q, data_d, up_data;
  logic     [ERR_CNT_WIDTH-1:0]  err_q, err_d;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : encode
    logic seen;
    enc  = '0;
    seen = 1'b0;
    for (int i = 0; i < ONEHOT_WIDTH; i++) begin
      if (in_onehot[i]) begin
        if (seen) enc.multi = 1'b1;
`ifdef ONEHOT_ENC_PRIORITY_EN
        if (!seen) enc.bin = BIN_WIDTH'(i);
`else
        enc.bin = enc.bin | BIN_WIDTH'(i);
`endif
        seen = 1'b1;
      end
    end
    enc.zero = !seen;
  end

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin : flow
    logic ld;
    load              = '0;
    ld                = out_ready || !valid_q[LATENCY-1];
    load[LATENCY-1]   = ld;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      ld      = ld || !valid_q[k];
      load[k] = ld;
    end
  end

  always_comb begin : upstream
    up_valid    = '0;
    up_data     = '0;
    up_valid[0] = in_valid;
    up_data[0]  = enc;
    for (int k = 1; k < LATENCY; k++) begin
      up_valid[k] = valid_q[k-1];
      up_data[k]  = data_q[k-1];
    end
  end

  // Payload only moves with a valid word, so idle cycles leave the outputs quiet.
  always_comb begin : advance
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < LATENCY; k++) begin
      if (load[k]) begin
        valid_d[k] = up_valid[k];
        if (up_valid[k]) data_d[k] = up_data[k];
      end
    end
  end

  always_comb begin : err_next
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (in_valid && in_ready && (enc.zero || enc.multi) && (err_q != '1)) begin
      err_d = err_q + ERR_CNT_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order. The payload
  // registers are reset as well because the outputs must read zero after reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[LATENCY-1];
  assign out_bin   = data_q[LATENCY-1].bin;
  assign out_zero  = data_q[LATENCY-1].zero;
  assign out_multi = data_q[LATENCY-1].multi;
  assign err_count = err_q;

endmodule

// File: tb/tb_onehot_enc_pipe.sv
// Randomized and directed bench for onehot_enc_pipe against a scoreboard model;
// a second instance with a 2-bit error counter exercises saturation.
module tb_onehot_enc_pipe;

  localparam int W   = 16;
  localparam int BW  = 4;
  localparam int L   = 2;
  localparam int EW  = 8;
  localparam int W2  = 12;
  localparam int BW2 = 4;
  localparam int L2  = 3;
  localparam int EW2 = 2;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic [W-1:0]   in_onehot;
  logic           in_valid, in_ready, out_zero, out_multi, out_valid, out_ready, err_clr;
  logic [BW-1:0]  out_bin;
  logic [EW-1:0]  err_count;

  logic [W2-1:0]  b_in_onehot;
  logic           b_in_valid, b_in_ready, b_out_zero, b_out_multi, b_out_valid, b_out_ready, b_err_clr;
  logic [BW2-1:0] b_out_bin;
  logic [EW2-1:0] b_err_count;

  onehot_enc_pipe #(.ONEHOT_WIDTH(W), .LATENCY(L), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .arst(arst), .in_onehot(in_onehot), .in_valid(in_valid), .in_ready(in_ready),
    .out_bin(out_bin), .out_zero(out_zero), .out_multi(out_multi), .out_valid(out_valid),
    .out_ready(out_ready), .err_clr(err_clr), .err_count(err_count)
  );

  onehot_enc_pipe #(.ONEHOT_WIDTH(W2), .LATENCY(L2), .ERR_CNT_WIDTH(EW2)) dut_sat (
    .clk(clk), .arst(arst), .in_onehot(b_in_onehot), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_bin(b_out_bin), .out_zero(b_out_zero), .out_multi(b_out_multi), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .err_clr(b_err_clr), .err_count(b_err_count)
  );

  typedef struct {
    logic [BW-1:0] bin;
    logic          zero;
    logic          multi;
    int            acc;
  } exp_t;

  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            last_stall = -100;
  int            err_model = 0;
  int            accepted = 0;
  logic          hold_pend = 1'b0;
  logic [BW-1:0] hold_bin;
  logic          hold_zero, hold_multi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Spec-level model: count set bits, pick lowest index or OR all indices.
  function automatic exp_t model(input logic [W-1:0] w);
    exp_t e;
    int   n   = 0;
    int   lo  = -1;
    int   orv = 0;
    for (int i = 0; i < W; i++) begin
      if (w[i]) begin
        n++;
        if (lo < 0) lo = i;
        orv = orv | i;
      end
    end
    e.zero  = (n == 0);
    e.multi = (n > 1);
`ifdef ONEHOT_ENC_PRIORITY_EN
    e.bin = (lo < 0) ? '0 : BW'(lo);
`else
    e.bin = BW'(orv);
`endif
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_word();
    int           r   = $urandom_range(0, 9);
    logic [W-1:0] one = 1;
    if (r < 5) return one << $urandom_range(0, W - 1);
    if (r == 5) return '0;
    return W'($urandom);
  endfunction

  // One clock: sample transfers at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e, m;
    @(negedge clk);
    cyc++;
    if (hold_pend) begin
      check("hold_valid", out_valid, 1);
      check("hold_bin", out_bin, hold_bin);
      check("hold_zero", out_zero, hold_zero);
      check("hold_multi", out_multi, hold_multi);
    end
    hold_pend  = out_valid && !out_ready;
    hold_bin   = out_bin;
    hold_zero  = out_zero;
    hold_multi = out_multi;
    if (!out_ready) last_stall = cyc;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_bin", out_bin, e.bin);
        check("out_zero", out_zero, e.zero);
        check("out_multi", out_multi, e.multi);
        if (last_stall <= e.acc) check("latency", cyc - e.acc, L);
      end
    end
    m = model(in_onehot);
    if (in_valid && in_ready) begin
      m.acc = cyc;
      q.push_back(m);
      accepted++;
    end
    if (err_clr) err_model = 0;
    else if (in_valid && in_ready && (m.zero || m.multi) && err_model < (1 << EW) - 1) err_model++;
    @(posedge clk);
    #1;
    check("err_count", err_count, err_model);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) cycle();
    check("drain_empty", q.size(), 0);
    check("drain_idle", out_valid, 0);
  endtask

  int stream_bins[3] = '{0, 7, 15};
  int sat_exp[5]     = '{1, 2, 3, 3, 3};
  logic [W-1:0] stream_words[3];
  int acc0;

  initial begin
    stream_words[0] = 16'h0001;
    stream_words[1] = 16'h0080;
    stream_words[2] = 16'h8000;
    arst = 1'b1;
    in_onehot = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    b_in_onehot = '0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bin", out_bin, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_multi", out_multi, 0);
    check("rst_err_count", err_count, 0);
    @(posedge clk);
    #1;

    // Consecutive one-hot stream with no back-pressure.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_onehot = stream_words[i];
      cycle();
      if (i >= 1) begin
        check("stream_valid", out_valid, 1);
        check("stream_bin", out_bin, stream_bins[i-1]);
      end
    end
    in_valid = 1'b0;
    cycle();
    check("stream_valid", out_valid, 1);
    check("stream_bin", out_bin, stream_bins[2]);
    drain();

    // Multi-hot word.
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    in_valid = 1'b1; in_onehot = 16'h0014; cycle(); in_valid = 1'b0;
    check("multi_err", err_count, 1);
    cycle();
    check("multi_valid", out_valid, 1);
`ifdef ONEHOT_ENC_PRIORITY_EN
    check("multi_bin", out_bin, 2);
`else
    check("multi_bin", out_bin, 6);
`endif
    check("multi_flag", out_multi, 1);
    check("multi_zero", out_zero, 0);
    drain();

    // Zero word together with err_clr.
    in_valid = 1'b1; in_onehot = '0; err_clr = 1'b1; cycle();
    in_valid = 1'b0; err_clr = 1'b0;
    check("zero_clr_err", err_count, 0);
    cycle();
    check("zero_valid", out_valid, 1);
    check("zero_bin", out_bin, 0);
    check("zero_flag", out_zero, 1);
    check("zero_multi", out_multi, 0);
    drain();

    // Back-pressure: a stalled pipe fills to its depth and then refuses input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc0      = accepted;
    for (int i = 0; i < 5; i++) begin
      in_onehot = rand_word();
      cycle();
    end
    check("bp_accepted", accepted - acc0, L);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    drain();

    // Saturating counter on the narrow instance.
    for (int i = 0; i < 5; i++) begin
      b_in_valid  = 1'b1;
      b_in_onehot = (i % 2 == 0) ? 12'h000 : 12'h003;
      @(posedge clk);
      #1;
      check("sat_err", b_err_count, sat_exp[i]);
    end
    b_in_valid = 1'b0;

    // Randomized traffic with random back-pressure and occasional clears.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_onehot = in_valid ? rand_word() : W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      err_clr   = ($urandom_range(0, 19) == 0);
      cycle();
    end
    err_clr = 1'b0;
    drain();

    // Asynchronous reset with two bad words in flight.
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    in_valid = 1'b1; in_onehot = '0; cycle();
    in_onehot = 16'h0003; cycle();
    in_valid = 1'b0;
    arst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_err_count", err_count, 0);
    check("arst_out_bin", out_bin, 0);
    q.delete();
    err_model = 0;
    hold_pend = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_idle", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_onehot = 16'h0040; cycle();
    in_valid = 1'b0;
    cycle();
    check("arst_new_valid", out_valid, 1);
    check("arst_new_bin", out_bin, 6);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
